// File: rtl/sim_rst_sequencer.sv
// sim_rst_sequencer: synchronizes deassertion of the raw reset, then releases
// NUM_DOMAINS per-domain resets one at a time (gap, release, wait for ack).
// Optional macro SIM_RST_SEQ_TIMEOUT_EN adds an ack timeout with a sticky
// timeout_err and a terminal ERROR state that re-asserts every domain reset.
module sim_rst_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DOMAINS = 3,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1024,
  localparam int IW = $clog2(NUM_DOMAINS + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_DOMAINS-1:0] domain_ack,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic [IW-1:0]          stage_idx,
  output logic                   all_released,
  output logic                   timeout_err
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  // Parameter legality, caught at elaboration
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_dom
    $error("NUM_DOMAINS must be 1..8");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 1");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_to
    $error("ACK_TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    SYNC     = 3'd0,
    GAP      = 3'd1,
    WAIT_ACK = 3'd2,
`ifdef SIM_RST_SEQ_TIMEOUT_EN
    ERROR    = 3'd4,
`endif
    DONE     = 3'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   srst_n;
  logic [GW-1:0]          gap_q, gap_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   all_q, all_d;
  logic                   err_q, err_d;
  logic [NUM_DOMAINS-1:0] sel_mask;
  logic                   ack_cur;

  // Deassertion synchronizer: assert asynchronously, release after SYNC_STAGES edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign srst_n = sync_q[SYNC_STAGES-1];

  // One-hot select of the domain currently being sequenced; only its ack matters
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NUM_DOMAINS; i++)
      if (idx_q == IW'(i)) sel_mask[i] = 1'b1;
    ack_cur = |(domain_ack & sel_mask);
  end

`ifdef SIM_RST_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;

  // Ack timeout counter, only meaningful in WAIT_ACK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_q <= '0;
    else          to_q <= to_d;
  end
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SYNC;
      gap_q   <= '0;
      rst_q   <= '1;
      idx_q   <= '0;
      all_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rst_q   <= rst_d;
      idx_q   <= idx_d;
      all_q   <= all_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rst_d   = rst_q;
    idx_d   = idx_q;
    all_d   = all_q;
    err_d   = err_q;
`ifdef SIM_RST_SEQ_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      SYNC: begin
        if (srst_n) begin
          state_d = GAP;
          gap_d   = '0;
          idx_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          rst_d   = rst_q & ~sel_mask;
          state_d = WAIT_ACK;
`ifdef SIM_RST_SEQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      WAIT_ACK: begin
        // An ack on the timeout edge still wins
        if (ack_cur) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(NUM_DOMAINS - 1)) begin
            state_d = DONE;
            all_d   = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
`ifdef SIM_RST_SEQ_TIMEOUT_EN
        else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = ERROR;
          err_d   = 1'b1;
          rst_d   = '1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      default: ; // DONE / ERROR are terminal until reset_n
    endcase
  end

  assign domain_rst   = rst_q;
  assign stage_idx    = idx_q;
  assign all_released = all_q;
`ifdef SIM_RST_SEQ_TIMEOUT_EN
  assign timeout_err  = err_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sim_rst_sequencer.sv
// Randomized bench for sim_rst_sequencer. The reference model derives the
// expected release/ack/error cycle numbers from per-domain ack delays with
// plain arithmetic, then checks every output after every posedge.
module tb_sim_rst_sequencer;

  localparam int N   = 3;
  localparam int G   = 4;
  localparam int TO  = 16;
  localparam int IW  = $clog2(N + 1);
  localparam int INF = 1 << 30;
`ifdef SIM_RST_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  domain_ack = '0;
  logic [N-1:0]  domain_rst;
  logic [IW-1:0] stage_idx;
  logic          all_released;
  logic          timeout_err;

  sim_rst_sequencer #(
    .SYNC_STAGES(2), .NUM_DOMAINS(N), .GAP_CYCLES(G), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .domain_ack(domain_ack),
    .domain_rst(domain_rst), .stage_idx(stage_idx),
    .all_released(all_released), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Single comparison point: count, and report any mismatch
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: ack delay per domain (cycles from release to ack sample)
  int dly  [N];
  int fall [N];   // posedge where domain_rst[i] falls (counted from reset release)
  int ackt [N];   // posedge where ack i is sampled high
  int win  [N];   // last posedge where ack i is observed by the sequencer
  int err_t, done_t;

  function automatic void build();
    int f;
    bit alive;
    f = 2 + G;           // t0 = posedge 2, release GAP cycles later
    alive = 1'b1;
    err_t = INF;
    done_t = INF;
    for (int i = 0; i < N; i++) begin
      fall[i] = INF; ackt[i] = INF; win[i] = INF;
      if (alive) begin
        fall[i] = f;
        if (TO_EN && dly[i] > TO) begin
          err_t  = f + TO;
          win[i] = err_t;
          alive  = 1'b0;
        end else begin
          ackt[i] = f + dly[i];
          win[i]  = ackt[i];
          f       = ackt[i] + G;
        end
      end
    end
    if (alive) done_t = ackt[N-1];
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rst"}, int'(domain_rst), (1 << N) - 1);
    chk({tag, ".idx"}, int'(stage_idx), 0);
    chk({tag, ".all"}, int'(all_released), 0);
    chk({tag, ".err"}, int'(timeout_err), 0);
  endtask

  task automatic check_cycle(input int p);
    int exp_rst, nack;
    exp_rst = 0;
    nack = 0;
    for (int i = 0; i < N; i++) begin
      if (p < fall[i]) exp_rst |= (1 << i);
      if (ackt[i] <= p) nack++;
    end
    if (p >= err_t) exp_rst = (1 << N) - 1;
    chk($sformatf("p%0d.rst", p), int'(domain_rst), exp_rst);
    chk($sformatf("p%0d.idx", p), int'(stage_idx), nack);
    chk($sformatf("p%0d.all", p), int'(all_released), (p >= done_t) ? 1 : 0);
    chk($sformatf("p%0d.err", p), int'(timeout_err), (p >= err_t) ? 1 : 0);
  endtask

  // One reset episode: short reset glitch, then run the sequence (optionally aborting)
  task automatic run(input bit hold, input int abort_p);
    int last;
    build();
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset_vals("async");
    #1 reset_n = 1'b1;
    last = (err_t != INF) ? err_t + 100 : done_t + 3;
    for (int p = 0; p <= last; p++) begin
      for (int i = 0; i < N; i++) begin
        if (fall[i] < p && p <= win[i]) domain_ack[i] = (p >= ackt[i]);
        else                            domain_ack[i] = hold ? 1'b1 : 1'($urandom);
      end
      @(posedge clk);
      #1 check_cycle(p);
      if (p == abort_p) begin
        #2 reset_n = 1'b0;
        #1 check_reset_vals("abort");
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    // Held in reset across clock edges
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      domain_ack = N'($urandom);
      @(posedge clk);
      #1 check_reset_vals("hold");
    end

    // Nominal: ack 3 cycles after each release
    dly = '{3, 3, 3};
    run(1'b0, -1);

    // Acks held high throughout
    dly = '{1, 1, 1};
    run(1'b1, -1);

    // Async reset while waiting for ack 1, then a clean rerun
    dly = '{3, 5, 2};
    build();
    run(1'b0, fall[1] + 2);
    dly = '{3, 3, 3};
    run(1'b0, -1);

    if (TO_EN) begin
      // Ack 1 never comes: error, then 100 held cycles
      dly = '{2, INF, 2};
      run(1'b0, -1);
      // Ack 1 on exactly the last allowed edge
      dly = '{4, TO, 1};
      run(1'b0, -1);
    end else begin
      // No timeout logic: long wait then completion
      dly = '{2, 2000, 3};
      run(1'b0, -1);
    end

    // Randomized episodes, some aborted mid-sequence
    for (int r = 0; r < 8; r++) begin
      int ab;
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, TO);
      build();
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, done_t) : -1;
      run(1'b0, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
